// File: rtl/branch_predictor.sv
// Tournament branch predictor: local, gshare and chooser 2-bit counter tables, trained at commit.
// Optional statistics counters are enabled by defining BRANCH_PREDICTOR_STATS_EN.
module branch_predictor #(
  parameter int LOCAL_WIDTH = 6
) (
  input  logic                   clk_in,
  input  logic                   rst_in_n,
  input  logic                   rdy_in,
  input  logic                   clear_signal,
  input  logic                   query_valid,
  input  logic [31:0]            query_pc,
  output logic                   pred_valid,
  output logic                   pred_taken,
  output logic [LOCAL_WIDTH-1:0] pred_addr,
  output logic [1:0]             pred_selection,
  input  logic                   predictor_signal,
  input  logic                   predictor_branch,
  input  logic [LOCAL_WIDTH-1:0] predictor_addr,
  input  logic [1:0]             predictor_selection
`ifdef BRANCH_PREDICTOR_STATS_EN
  ,
  output logic [31:0]            stat_total,
  output logic [31:0]            stat_miss
`endif
);

  localparam int TABLE_SIZE = 1 << LOCAL_WIDTH;

  logic [1:0]             localTable_q   [TABLE_SIZE];
  logic [1:0]             globalTable_q  [TABLE_SIZE];
  logic [1:0]             chooserTable_q [TABLE_SIZE];
  logic [LOCAL_WIDTH-1:0] ghr_q;
  logic [LOCAL_WIDTH-1:0] ghr_d;

  logic                   predValid_q;
  logic                   predTaken_q;
  logic [LOCAL_WIDTH-1:0] predAddr_q;
  logic [1:0]             predSelection_q;
  logic                   predValid_d;
  logic                   predTaken_d;
  logic [LOCAL_WIDTH-1:0] predAddr_d;
  logic [1:0]             predSelection_d;

  logic [LOCAL_WIDTH-1:0] queryIdx;
  logic [LOCAL_WIDTH-1:0] queryGlobalIdx;
  logic                   queryLocalPred;
  logic                   queryGlobalPred;
  logic                   queryUseGlobal;

  logic [LOCAL_WIDTH-1:0] updGlobalIdx;
  logic [1:0]             localNext_d;
  logic [1:0]             globalNext_d;
  logic [1:0]             chooserNext_d;
  logic                   chooserWrite;

  logic                   unusedPcBits;

  function automatic logic [1:0] satUpdate(input logic [1:0] cnt, input logic up);
    logic [1:0] res;
    if (up) res = (cnt == 2'b11) ? 2'b11 : cnt + 2'd1;
    else    res = (cnt == 2'b00) ? 2'b00 : cnt - 2'd1;
    return res;
  endfunction

  assign unusedPcBits = ^{query_pc[31:LOCAL_WIDTH+2], query_pc[1:0]};

  // Query path reads only registered state, so a same-cycle update is never bypassed.
  always_comb begin
    queryIdx        = query_pc[LOCAL_WIDTH+1:2];
    queryGlobalIdx  = queryIdx ^ ghr_q;
    queryLocalPred  = localTable_q[queryIdx][1];
    queryGlobalPred = globalTable_q[queryGlobalIdx][1];
    queryUseGlobal  = chooserTable_q[queryIdx][1];
  end

  always_comb begin
    predValid_d     = 1'b0;
    predTaken_d     = predTaken_q;
    predAddr_d      = predAddr_q;
    predSelection_d = predSelection_q;
    if (query_valid && !clear_signal) begin
      predValid_d     = 1'b1;
      predTaken_d     = queryUseGlobal ? queryGlobalPred : queryLocalPred;
      predAddr_d      = queryIdx;
      predSelection_d = {queryLocalPred, queryGlobalPred};
    end
  end

  // The chooser only learns when the two components disagreed at query time.
  always_comb begin
    updGlobalIdx  = predictor_addr ^ ghr_q;
    localNext_d   = satUpdate(localTable_q[predictor_addr], predictor_branch);
    globalNext_d  = satUpdate(globalTable_q[updGlobalIdx], predictor_branch);
    chooserWrite  = predictor_selection[1] != predictor_selection[0];
    chooserNext_d = satUpdate(chooserTable_q[predictor_addr],
                              predictor_selection[0] == predictor_branch);
    ghr_d         = {ghr_q[LOCAL_WIDTH-2:0], predictor_branch};
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      for (int i = 0; i < TABLE_SIZE; i++) begin
        localTable_q[i]   <= 2'b01;
        globalTable_q[i]  <= 2'b01;
        chooserTable_q[i] <= 2'b10;
      end
      ghr_q <= '0;
    end else if (rdy_in && predictor_signal) begin
      localTable_q[predictor_addr] <= localNext_d;
      globalTable_q[updGlobalIdx]  <= globalNext_d;
      if (chooserWrite) chooserTable_q[predictor_addr] <= chooserNext_d;
      ghr_q <= ghr_d;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      predValid_q     <= 1'b0;
      predTaken_q     <= 1'b0;
      predAddr_q      <= '0;
      predSelection_q <= 2'b00;
    end else if (rdy_in) begin
      predValid_q     <= predValid_d;
      predTaken_q     <= predTaken_d;
      predAddr_q      <= predAddr_d;
      predSelection_q <= predSelection_d;
    end
  end

  assign pred_valid     = predValid_q;
  assign pred_taken     = predTaken_q;
  assign pred_addr      = predAddr_q;
  assign pred_selection = predSelection_q;

`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] statTotal_q;
  logic [31:0] statMiss_q;
  logic        statChosen;

  // Miss accounting uses the chooser value before this commit's training.
  assign statChosen = chooserTable_q[predictor_addr][1] ? predictor_selection[0]
                                                        : predictor_selection[1];

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      statTotal_q <= '0;
      statMiss_q  <= '0;
    end else if (rdy_in && predictor_signal) begin
      statTotal_q <= statTotal_q + 32'd1;
      if (statChosen != predictor_branch) statMiss_q <= statMiss_q + 32'd1;
    end
  end

  assign stat_total = statTotal_q;
  assign stat_miss  = statMiss_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: queries push expected predictions,
// a monitor pops and compares them whenever a fresh pred_valid appears.
module tb_branch_predictor;

  logic        clk_in;
  logic        rst_in_n;
  logic        rdy_in;
  logic        clear_signal;
  logic        query_valid;
  logic [31:0] query_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [5:0]  pred_addr;
  logic [1:0]  pred_selection;
  logic        predictor_signal;
  logic        predictor_branch;
  logic [5:0]  predictor_addr;
  logic [1:0]  predictor_selection;
`ifdef BRANCH_PREDICTOR_STATS_EN
  logic [31:0] stat_total;
  logic [31:0] stat_miss;
`endif

  typedef struct {
    string      name;
    logic       taken;
    logic [5:0] addr;
    logic [1:0] sel;
  } predExp_t;

  predExp_t expQ[$];
  int assertions = 0;
  int failures   = 0;

  branch_predictor #(.LOCAL_WIDTH(6)) dut (
    .clk_in              (clk_in),
    .rst_in_n            (rst_in_n),
    .rdy_in              (rdy_in),
    .clear_signal        (clear_signal),
    .query_valid         (query_valid),
    .query_pc            (query_pc),
    .pred_valid          (pred_valid),
    .pred_taken          (pred_taken),
    .pred_addr           (pred_addr),
    .pred_selection      (pred_selection),
    .predictor_signal    (predictor_signal),
    .predictor_branch    (predictor_branch),
    .predictor_addr      (predictor_addr),
    .predictor_selection (predictor_selection)
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    .stat_total          (stat_total),
    .stat_miss           (stat_miss)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  // Monitor: only results latched on an edge with rdy high and reset released are new.
  initial begin
    logic     sampledRdy;
    predExp_t e;
    forever begin
      @(posedge clk_in);
      sampledRdy = rdy_in && rst_in_n;
      #1;
      if (sampledRdy && pred_valid) begin
        assertions++;
        if (expQ.size() == 0) begin
          failures++;
          $display("[TB] FAIL unexpected pred_valid: got addr=%0d sel=%b, expected no result",
                   pred_addr, pred_selection);
        end else begin
          e = expQ.pop_front();
          if ({pred_taken, pred_addr, pred_selection} !== {e.taken, e.addr, e.sel}) begin
            failures++;
            $display("[TB] FAIL %s: got taken=%0b addr=%0d sel=%b, expected taken=%0b addr=%0d sel=%b",
                     e.name, pred_taken, pred_addr, pred_selection, e.taken, e.addr, e.sel);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One cycle of stimulus, driven at a negedge and held until the next negedge.
  task automatic applyStimulus(input logic qv, input logic [31:0] pc, input logic us,
                               input logic ub, input logic [5:0] ua, input logic [1:0] usel,
                               input logic clr, input logic rdy);
    query_valid         = qv;
    query_pc            = pc;
    predictor_signal    = us;
    predictor_branch    = ub;
    predictor_addr      = ua;
    predictor_selection = usel;
    clear_signal        = clr;
    rdy_in              = rdy;
    @(negedge clk_in);
  endtask

  task automatic expectPred(input string name, input logic taken, input logic [5:0] addr,
                            input logic [1:0] sel);
    predExp_t e;
    e.name = name; e.taken = taken; e.addr = addr; e.sel = sel;
    expQ.push_back(e);
  endtask

  task automatic query(input string name, input logic [31:0] pc, input logic taken,
                       input logic [5:0] addr, input logic [1:0] sel);
    expectPred(name, taken, addr, sel);
    applyStimulus(1'b1, pc, 1'b0, 1'b0, 6'd0, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic update(input logic [5:0] addr, input logic t, input logic [1:0] sel);
    applyStimulus(1'b0, 32'h0, 1'b1, t, addr, sel, 1'b0, 1'b1);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 6'd0, 2'b00, 1'b0, 1'b1);
  endtask

  initial begin
    rst_in_n = 1'b1;
    rdy_in = 1'b1; clear_signal = 1'b0; query_valid = 1'b0; query_pc = '0;
    predictor_signal = 1'b0; predictor_branch = 1'b0; predictor_addr = '0;
    predictor_selection = 2'b00;
    #3 rst_in_n = 1'b0;
    @(negedge clk_in);
    @(negedge clk_in);
    checkOutput("reset pred_valid", 32'(pred_valid), 32'd0);
    checkOutput("reset pred_taken", 32'(pred_taken), 32'd0);
    checkOutput("reset pred_addr", 32'(pred_addr), 32'd0);
    checkOutput("reset pred_selection", 32'(pred_selection), 32'd0);
    rst_in_n = 1'b1;
    idle();

    query("first query pc 0x100", 32'h100, 1'b0, 6'd0, 2'b00);
    idle();

    // local[5] saturates at 3, GHR becomes 7, global[5],[4],[6] = 2
    for (int i = 0; i < 3; i++) update(6'd5, 1'b1, 2'b00);
    query("trained local pc 0x14", 32'h14, 1'b0, 6'd5, 2'b10);
    query("gshare via GHR pc 0x08", 32'h08, 1'b1, 6'd2, 2'b01);
    idle();

    // local[5] to 0; GHR walks 14,28,56,48,32
    for (int i = 0; i < 5; i++) update(6'd5, 1'b0, 2'b00);
    query("local saturates low", 32'h14, 1'b0, 6'd5, 2'b00);
    update(6'd5, 1'b1, 2'b00);
    query("local from floor", 32'h14, 1'b1, 6'd5, 2'b01);
    idle();

    // chooser[3]: 2->3->2->1; then local[3] trained to 2, GHR = 51
    update(6'd3, 1'b1, 2'b01);
    update(6'd3, 1'b0, 2'b01);
    update(6'd3, 1'b0, 2'b01);
    update(6'd3, 1'b1, 2'b11);
    update(6'd3, 1'b1, 2'b11);
    query("chooser selects local", 32'h0C, 1'b1, 6'd3, 2'b10);
    idle();

    expectPred("same-cycle pre-update", 1'b0, 6'd5, 2'b00);
    applyStimulus(1'b1, 32'h14, 1'b1, 1'b1, 6'd5, 2'b00, 1'b0, 1'b1);
    query("update visible next", 32'h14, 1'b0, 6'd5, 2'b10);
    idle();

    query("before stall", 32'h08, 1'b1, 6'd2, 2'b01);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h14, 1'b1, 1'b0, 6'd2, 2'b00, 1'b0, 1'b0);
      checkOutput("stall holds pred_valid", 32'(pred_valid), 32'd1);
      checkOutput("stall holds pred_addr", 32'(pred_addr), 32'd2);
    end
    idle();
    query("stall applied nothing", 32'h08, 1'b1, 6'd2, 2'b01);

    // flush with commit: local[5]=3, global[34]=2, GHR=15
    applyStimulus(1'b1, 32'h14, 1'b1, 1'b1, 6'd5, 2'b00, 1'b1, 1'b1);
    checkOutput("flush drops pred_valid", 32'(pred_valid), 32'd0);
    checkOutput("flush holds pred_addr", 32'(pred_addr), 32'd2);
    query("update kept under flush", 32'hB4, 1'b1, 6'd45, 2'b01);
    idle();

    query("before async reset", 32'hB4, 1'b1, 6'd45, 2'b01);
    #2 rst_in_n = 1'b0;
    #1;
    checkOutput("async reset pred_valid", 32'(pred_valid), 32'd0);
    checkOutput("async reset pred_taken", 32'(pred_taken), 32'd0);
    checkOutput("async reset pred_addr", 32'(pred_addr), 32'd0);
    checkOutput("async reset pred_selection", 32'(pred_selection), 32'd0);
    @(negedge clk_in);
    rst_in_n = 1'b1;
    query("tables reset", 32'hB4, 1'b0, 6'd45, 2'b00);
    idle();
    idle();
    idle();
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Tournament branch predictor that serves prediction queries from instruction fetch.
- Trains on the branch-commit stream driven by the reorder buffer: predictor_signal, predictor_branch, predictor_addr and predictor_selection.
- Prediction components: a local 2-bit counter table, a global (gshare) 2-bit counter table and a 2-bit chooser table.
- Fetch embeds the returned index and selection into the ROB branch entry; they come back unchanged at commit.

Parameters:
- LOCAL_WIDTH, 6: table index width; each table has 2**LOCAL_WIDTH entries; also the global history register (GHR) width.

Ports:
- clk_in  input  1  system clock
- rst_in_n  input  1  asynchronous active-low reset
- rdy_in  input  1  when low, freeze all state; outputs hold
- clear_signal  input  1  misprediction flush from ROB
- query_valid  input  1  fetch requests a prediction this cycle
- query_pc  input  32  PC of the branch being fetched
- pred_valid  output  1  prediction result valid (one-cycle pulse)
- pred_taken  output  1  predicted direction
- pred_addr  output  LOCAL_WIDTH  local index used (query_pc[LOCAL_WIDTH+1:2])
- pred_selection  output  2  {local_pred, global_pred} component predictions
- predictor_signal  input  1  commit of a branch this cycle
- predictor_branch  input  1  actual outcome, 1 = taken
- predictor_addr  input  LOCAL_WIDTH  index returned at query time
- predictor_selection  input  2  selection returned at query time

Behaviour:
- Reset (rst_in_n low, asynchronous):
  - local and global counters = 2'b01
  - chooser counters = 2'b10
  - GHR = 0
  - pred_valid = 0; pred_taken = 0; pred_addr = 0; pred_selection = 0
- All updates on posedge clk_in, and only when rdy_in = 1.
- Query (latency 1):
  - On a cycle with query_valid = 1 and clear_signal = 0, compute:
    - L = query_pc[LOCAL_WIDTH+1:2]
    - G = L ^ GHR
    - lp = local[L][1]
    - gp = global[G][1]
    - choose global if chooser[L][1] = 1
  - Next cycle: pred_valid = 1, pred_taken = chosen prediction, pred_addr = L, pred_selection = {lp, gp}.
  - Otherwise pred_valid = 0 next cycle; the other prediction outputs hold their values.
- Flush: clear_signal = 1 forces pred_valid = 0 next cycle, even with query_valid = 1. Tables and GHR are not modified by a flush.
- Update: when predictor_signal = 1, with A = predictor_addr, t = predictor_branch, {lp, gp} = predictor_selection:
  - local[A]: saturating increment if t, else saturating decrement; range 0..3, no wrap.
  - global[A ^ GHR]: same rule, using GHR before this cycle's shift.
  - chooser[A], only if lp != gp: increment (saturating) if gp == t, else decrement (saturating).
  - GHR = {GHR[LOCAL_WIDTH-2:0], t}.
- History policy: the GHR is non-speculative (updated at commit only), so a flush needs no rollback. The global index used at update may differ from the one used at query; this is accepted by design.
- Simultaneous query and update in one cycle:
  - the query reads pre-update tables and the pre-update GHR (no bypass);
  - the update still applies.
- Update and clear_signal in the same cycle: the update applies. The ROB asserts predictor_signal in the same cycle as a mispredict clear, and that update must not be lost.
- rdy_in = 0: no table, GHR or output register changes, including pred_valid. A pending query result holds until rdy_in returns high.

Optional Feature:
- Macro: BRANCH_PREDICTOR_STATS_EN.
- When defined, add two outputs: stat_total (32 bits) and stat_miss (32 bits), both reset to 0.
  - On each applied update, stat_total += 1.
  - stat_miss += 1 when the update's chosen component prediction != t. The chosen prediction is recomputed as gp if chooser[A][1] = 1, else lp, using the chooser value before this cycle's update.
  - Both counters wrap modulo 2**32.
- When undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then query_pc = 0x0000_0100 -> next cycle pred_valid = 1, pred_taken = 0, pred_addr = 0x00, pred_selection = 2'b00.
- Three updates: addr 0x05, taken, selection 2'b00 -> local[5] = 3; GHR = 6'b000111. A subsequent query to pc 0x14 returns pred_selection[1] = 1; pred_taken follows global[5 ^ 7 = 2] (1 if trained).
- Saturation: five not-taken updates on addr 0x05 -> local[5] = 0, with no wrap to 3.
- Chooser: update addr 0x03, t = 1, selection 2'b01 -> chooser[3] = 3. Update t = 0, selection 2'b01, twice -> chooser[3] = 1, so local is selected.
- Same-cycle query to index 0x05 plus update of addr 0x05 -> prediction uses pre-update counters. The update is visible on the following query.
- clear_signal = 1 with query_valid = 1 and predictor_signal = 1 -> pred_valid = 0 next cycle, yet the update is applied (tables and GHR checked). Reset asserted mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
